mem_arbiter: RTL

Shared-memory responder and bus arbiter on the far end of the core's grant/rw/address/data bus. Accepts grant requests from NUM_CORES cores, grants exactly one at a time in round-robin order, and serves that core's byte reads and writes against a 512 x 8 on-chip memory. Sits between the core array and memory at the top level. Cores act as initiators; this block is the only responder.

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Purpose: round-robin bus arbiter and sole responder for a shared 512 x 8 byte memory.
// Latency: grant one edge after a request in IDLE; read data one edge after the address is sampled; writes commit on the sampling edge.
// Backpressure: one core owns the bus at a time; the others wait with grant_request held high until they are granted.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-low reset
//   grant_request  per-core bus request (bit i = core i)
//   grant_given    registered one-hot-or-zero grant
//   rw             per-core access type, 1 = write, 0 = read
//   address        per-core 9-bit byte address, core i at [9i+8:9i]
//   wr_data        per-core write byte, core i at [8i+7:8i]
//   rd_data        registered read byte, broadcast to all cores
module mem_arbiter #(
  parameter int NUM_CORES = 2,
  parameter int MAX_HOLD  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CORES-1:0]   grant_request,
  output logic [NUM_CORES-1:0]   grant_given,
  input  logic [NUM_CORES-1:0]   rw,
  input  logic [9*NUM_CORES-1:0] address,
  input  logic [8*NUM_CORES-1:0] wr_data,
  output logic [7:0]             rd_data
);

  localparam int OW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [NUM_CORES-1:0] ONE_LSB = {{(NUM_CORES-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [OW-1:0]        owner, owner_nxt;
  logic [OW-1:0]        last_owner, last_owner_nxt;
  logic [HW-1:0]        hold_cnt, hold_cnt_nxt;
  logic [NUM_CORES-1:0] grant_nxt;
  logic                 access;

  logic [7:0] mem [512];

  // Per-core views of the flat address/data buses.
  logic [8:0] addr_arr [NUM_CORES];
  logic [7:0] wdat_arr [NUM_CORES];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_split
    assign addr_arr[g] = address[9*g +: 9];
    assign wdat_arr[g] = wr_data[8*g +: 8];
  end

  logic                 own_req;
  logic                 own_rw;
  logic [8:0]           own_addr;
  logic [7:0]           own_wdat;
  logic [NUM_CORES-1:0] owner_oh;
  logic                 others_req;
  logic                 hold_limit;
  logic [HW-1:0]        hold_inc;

  assign own_req    = grant_request[owner];
  assign own_rw     = rw[owner];
  assign own_addr   = addr_arr[owner];
  assign own_wdat   = wdat_arr[owner];
  assign owner_oh   = ONE_LSB << owner;
  assign others_req = |(grant_request & ~owner_oh);
  // At MAX_HOLD-1 this access reaches the limit; at MAX_HOLD the tenure is
  // already saturated and yields to the first competing request.
  assign hold_limit = (hold_cnt >= HW'(MAX_HOLD - 1));
  assign hold_inc   = (hold_cnt == HW'(MAX_HOLD)) ? hold_cnt : hold_cnt + HW'(1);

  // Round-robin scan starting just after the previous owner.
  logic [OW:0]   rr_sum;
  logic [OW-1:0] rr_winner;
  logic          rr_found;

  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    rr_sum    = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      rr_sum = {1'b0, last_owner} + (OW+1)'(k);
      if (rr_sum >= (OW+1)'(NUM_CORES)) begin
        rr_sum = rr_sum - (OW+1)'(NUM_CORES);
      end
      if (!rr_found && grant_request[rr_sum[OW-1:0]]) begin
        rr_found  = 1'b1;
        rr_winner = rr_sum[OW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    hold_cnt_nxt   = hold_cnt;
    grant_nxt      = grant_given;
    access         = 1'b0;
    case (state)
      IDLE: begin
        if (rr_found) begin
          state_nxt    = OWNED;
          owner_nxt    = rr_winner;
          hold_cnt_nxt = '0;
          grant_nxt    = ONE_LSB << rr_winner;
        end
      end
      OWNED: begin
        access = own_req;
        if (own_req) begin
          hold_cnt_nxt = hold_inc;
        end
        // The access on the releasing edge still completes.
        if (!own_req || (hold_limit && others_req)) begin
          state_nxt      = IDLE;
          grant_nxt      = '0;
          last_owner_nxt = owner;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= '0;
      last_owner  <= OW'(NUM_CORES - 1);
      hold_cnt    <= '0;
      grant_given <= '0;
      rd_data     <= 8'h00;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_owner  <= last_owner_nxt;
      hold_cnt    <= hold_cnt_nxt;
      grant_given <= grant_nxt;
      if (access && !own_rw) begin
        rd_data <= mem[own_addr];
      end
    end
  end

  // Memory contents survive reset; a write presented while reset is low is dropped.
  always_ff @(posedge clk) begin
    if (reset && access && own_rw) begin
      mem[own_addr] <= own_wdat;
    end
  end

endmodule
